// File: rtl/rv_timer_pkg.sv
// Shared constants for the rv_timer_dev machine-timer device: register offsets,
// CTRL field layout, mtimecmp reset value and a byte-lane merge helper.
package rv_timer_pkg;

   localparam logic [9:0] MTIME_LO_OFFSET    = 10'h000;
   localparam logic [9:0] MTIME_HI_OFFSET    = 10'h004;
   localparam logic [9:0] MTIMECMP_LO_OFFSET = 10'h008;
   localparam logic [9:0] MTIMECMP_HI_OFFSET = 10'h00C;
   localparam logic [9:0] CTRL_OFFSET        = 10'h010;
   localparam logic [9:0] STATUS_OFFSET      = 10'h014;

   localparam logic [7:0] NumRegWords = 8'd6;

   localparam int CtrlEnBit         = 0;
   localparam int CtrlPrescaleLsb   = 8;
   localparam int CtrlPrescaleWidth = 16;

   localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/rv_timer_tick.sv
// Prescale counter: counts up while enabled and emits a one-cycle tick when it
// reaches the prescale value, then restarts from zero.
module rv_timer_tick
   import rv_timer_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         en_i,
   input  logic                         clear_i,
   input  logic [CtrlPrescaleWidth-1:0] prescale_i,
   output logic                         tick_o
);

   logic [CtrlPrescaleWidth-1:0] count_q;
   logic                         at_terminal;

   assign at_terminal = (count_q == prescale_i);
   // A CTRL write only restarts the count; a tick due in that cycle still fires.
   assign tick_o      = en_i && at_terminal;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= at_terminal ? '0 : count_q + 1'b1;
      end
   end

endmodule

// File: rtl/rv_timer_dev.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled tick, single-cycle
// bus response and a registered level interrupt for the core.
module rv_timer_dev
   import rv_timer_pkg::*;
#(
   parameter int          DataWidth     = 32,
   parameter int          AddressWidth  = 32,
   parameter logic [15:0] PrescaleReset = 16'h0000
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    dev_req_i,
   input  logic                    dev_we_i,
   input  logic [3:0]              dev_be_i,
   input  logic [AddressWidth-1:0] dev_addr_i,
   input  logic [DataWidth-1:0]    dev_wdata_i,
   output logic                    dev_rvalid_o,
   output logic [DataWidth-1:0]    dev_rdata_o,
   output logic                    dev_err_o,
   output logic                    irq_timer_o
);

   logic [63:0]                  mtime_q, mtime_d;
   logic [63:0]                  mtimecmp_q, mtimecmp_d;
   logic                         ctrl_en_q, ctrl_en_d;
   logic [CtrlPrescaleWidth-1:0] prescale_q, prescale_d;
   logic                         ctrl_clear;
   logic                         tick;

   logic [9:0]  offset;
   logic        in_range;
   logic        acc_err;
   logic        wr;
   logic        rd;
   logic [31:0] ctrl_rd;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign offset   = {dev_addr_i[9:2], 2'b00};
   assign in_range = (dev_addr_i[9:2] < NumRegWords);
   assign acc_err  = dev_req_i && (!in_range || (dev_we_i && offset == STATUS_OFFSET));
   assign wr       = dev_req_i && dev_we_i && !acc_err;
   assign rd       = dev_req_i && !dev_we_i && !acc_err;

   assign unused_bits = ^{dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0], dev_be_i[3]};

   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[CtrlEnBit] = ctrl_en_q;
      ctrl_rd[CtrlPrescaleLsb +: CtrlPrescaleWidth] = prescale_q;
   end

   rv_timer_tick u_tick (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (ctrl_en_q),
      .clear_i    (ctrl_clear),
      .prescale_i (prescale_q),
      .tick_o     (tick)
   );

   // Software writes to mtime override the tick for that cycle.
   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      ctrl_en_d  = ctrl_en_q;
      prescale_d = prescale_q;
      ctrl_clear = 1'b0;
      if (tick) mtime_d = mtime_q + 64'd1;
      if (wr) begin
         unique case (offset)
            MTIME_LO_OFFSET:
               mtime_d = {mtime_q[63:32], apply_be(mtime_q[31:0], dev_wdata_i, dev_be_i)};
            MTIME_HI_OFFSET:
               mtime_d = {apply_be(mtime_q[63:32], dev_wdata_i, dev_be_i), mtime_q[31:0]};
            MTIMECMP_LO_OFFSET:
               mtimecmp_d = {mtimecmp_q[63:32], apply_be(mtimecmp_q[31:0], dev_wdata_i, dev_be_i)};
            MTIMECMP_HI_OFFSET:
               mtimecmp_d = {apply_be(mtimecmp_q[63:32], dev_wdata_i, dev_be_i), mtimecmp_q[31:0]};
            CTRL_OFFSET: begin
               ctrl_clear = 1'b1;
               if (dev_be_i[0]) ctrl_en_d = dev_wdata_i[CtrlEnBit];
               if (dev_be_i[1]) prescale_d[7:0] = dev_wdata_i[CtrlPrescaleLsb +: 8];
               if (dev_be_i[2]) prescale_d[15:8] = dev_wdata_i[CtrlPrescaleLsb+8 +: 8];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (offset)
         MTIME_LO_OFFSET:    rd_mux = mtime_q[31:0];
         MTIME_HI_OFFSET:    rd_mux = mtime_q[63:32];
         MTIMECMP_LO_OFFSET: rd_mux = mtimecmp_q[31:0];
         MTIMECMP_HI_OFFSET: rd_mux = mtimecmp_q[63:32];
         CTRL_OFFSET:        rd_mux = ctrl_rd;
         STATUS_OFFSET:      rd_mux = {31'd0, irq_timer_o};
         default:            rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dev_rvalid_o <= 1'b0;
         dev_rdata_o  <= '0;
         dev_err_o    <= 1'b0;
         irq_timer_o  <= 1'b0;
         mtime_q      <= '0;
         mtimecmp_q   <= MtimecmpReset;
         ctrl_en_q    <= 1'b0;
         prescale_q   <= PrescaleReset;
      end else begin
         dev_rvalid_o <= dev_req_i;
         dev_err_o    <= acc_err;
         dev_rdata_o  <= rd ? rd_mux : '0;
         irq_timer_o  <= ctrl_en_d && (mtime_d >= mtimecmp_d);
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         ctrl_en_q    <= ctrl_en_d;
         prescale_q   <= prescale_d;
      end
   end

endmodule

// File: tb/tb_rv_timer_dev.sv
// Directed bench for rv_timer_dev: register access, prescaled counting, interrupt,
// wrap, byte enables, error responses and asynchronous reset.
module tb_rv_timer_dev;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        dev_req_i;
   logic        dev_we_i;
   logic [3:0]  dev_be_i;
   logic [31:0] dev_addr_i;
   logic [31:0] dev_wdata_i;
   logic        dev_rvalid_o;
   logic [31:0] dev_rdata_o;
   logic        dev_err_o;
   logic        irq_timer_o;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   rv_timer_dev dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .dev_req_i    (dev_req_i),
      .dev_we_i     (dev_we_i),
      .dev_be_i     (dev_be_i),
      .dev_addr_i   (dev_addr_i),
      .dev_wdata_i  (dev_wdata_i),
      .dev_rvalid_o (dev_rvalid_o),
      .dev_rdata_o  (dev_rdata_o),
      .dev_err_o    (dev_err_o),
      .irq_timer_o  (irq_timer_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called right after a negedge; request is sampled on the next posedge and the
   // response is checked on the following negedge.
   task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
      dev_req_i   = 1'b1;
      dev_we_i    = we;
      dev_be_i    = be;
      dev_addr_i  = addr;
      dev_wdata_i = wdata;
      @(negedge clk_i);
      chk("rvalid", {63'd0, dev_rvalid_o}, 64'd1);
      rdata       = dev_rdata_o;
      err         = dev_err_o;
      dev_req_i   = 1'b0;
      dev_we_i    = 1'b0;
      dev_be_i    = 4'h0;
      dev_wdata_i = 32'h0;
   endtask

   task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] r;
      logic        e;
      bus(1'b1, 4'hF, addr, data, r, e);
      chk("wr_err", {63'd0, e}, 64'd0);
   endtask

   task automatic rd32(input logic [31:0] addr, output logic [31:0] data);
      logic e;
      bus(1'b0, 4'h0, addr, 32'h0, data, e);
      chk("rd_err", {63'd0, e}, 64'd0);
   endtask

   initial begin
      logic [31:0] r, r1, r2;
      logic        e;

      rst_ni      = 1'b0;
      dev_req_i   = 1'b0;
      dev_we_i    = 1'b0;
      dev_be_i    = 4'h0;
      dev_addr_i  = 32'h0;
      dev_wdata_i = 32'h0;
      repeat (2) @(negedge clk_i);
      chk("rst_rvalid", {63'd0, dev_rvalid_o}, 64'd0);
      chk("rst_irq", {63'd0, irq_timer_o}, 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Reset values, back-to-back reads
      rd32(32'h00, r); chk("rst_mtime_lo", {32'd0, r}, 64'h0);
      rd32(32'h04, r); chk("rst_mtime_hi", {32'd0, r}, 64'h0);
      rd32(32'h08, r); chk("rst_cmp_lo", {32'd0, r}, 64'hFFFF_FFFF);
      rd32(32'h0C, r); chk("rst_cmp_hi", {32'd0, r}, 64'hFFFF_FFFF);
      rd32(32'h10, r); chk("rst_ctrl", {32'd0, r}, 64'h0);
      rd32(32'h14, r); chk("rst_status", {32'd0, r}, 64'h0);
      @(negedge clk_i);
      chk("idle_rvalid", {63'd0, dev_rvalid_o}, 64'd0);

      // Prescale 3: one tick every four cycles
      wr32(32'h10, 32'h0000_0301);
      repeat (40) @(negedge clk_i);
      rd32(32'h00, r); chk("presc3_mtime", {32'd0, r}, 64'd10);
      rd32(32'h10, r); chk("presc3_ctrl", {32'd0, r}, 64'h301);

      // Prescale 0: read deltas equal cycle deltas
      wr32(32'h10, 32'h0);
      wr32(32'h00, 32'h0);
      wr32(32'h04, 32'h0);
      wr32(32'h10, 32'h1);
      rd32(32'h00, r1);
      repeat (7) @(negedge clk_i);
      rd32(32'h00, r2);
      chk("presc0_first", {32'd0, r1}, 64'd0);
      chk("presc0_delta", {32'd0, r2 - r1}, 64'd8);

      // Compare match raises irq, raising mtimecmp clears it
      wr32(32'h10, 32'h0);
      wr32(32'h0C, 32'h0);
      wr32(32'h08, 32'h20);
      wr32(32'h00, 32'h0);
      wr32(32'h04, 32'h0);
      wr32(32'h10, 32'h1);
      chk("irq_start", {63'd0, irq_timer_o}, 64'd0);
      repeat (31) @(negedge clk_i);
      chk("irq_before", {63'd0, irq_timer_o}, 64'd0);
      @(negedge clk_i);
      chk("irq_match", {63'd0, irq_timer_o}, 64'd1);
      rd32(32'h14, r); chk("status_set", {32'd0, r}, 64'd1);
      wr32(32'h08, 32'h1000);
      chk("irq_cleared", {63'd0, irq_timer_o}, 64'd0);

      // 64-bit wrap with mtimecmp=0
      wr32(32'h10, 32'h0);
      wr32(32'h08, 32'h0);
      wr32(32'h0C, 32'h0);
      wr32(32'h04, 32'hFFFF_FFFF);
      wr32(32'h00, 32'hFFFF_FFFE);
      chk("wrap_irq_off", {63'd0, irq_timer_o}, 64'd0);
      wr32(32'h10, 32'h1);
      chk("wrap_irq0", {63'd0, irq_timer_o}, 64'd1);
      @(negedge clk_i);
      chk("wrap_irq1", {63'd0, irq_timer_o}, 64'd1);
      @(negedge clk_i);
      chk("wrap_irq2", {63'd0, irq_timer_o}, 64'd1);
      rd32(32'h00, r); chk("wrap_lo", {32'd0, r}, 64'd0);
      rd32(32'h04, r); chk("wrap_hi", {32'd0, r}, 64'd0);
      chk("wrap_irq3", {63'd0, irq_timer_o}, 64'd1);

      // Byte enables and error responses
      wr32(32'h10, 32'h0);
      wr32(32'h08, 32'hFFFF_FFFF);
      bus(1'b1, 4'b0010, 32'h08, 32'hAABB_CCDD, r, e);
      chk("be_wr_err", {63'd0, e}, 64'd0);
      rd32(32'h08, r); chk("be_cmp_lo", {32'd0, r}, 64'hFFFF_CCFF);
      bus(1'b1, 4'hF, 32'h14, 32'hFFFF_FFFF, r, e);
      chk("status_wr_err", {63'd0, e}, 64'd1);
      chk("status_wr_rdata", {32'd0, r}, 64'd0);
      rd32(32'h14, r); chk("status_after", {32'd0, r}, 64'd0);
      bus(1'b0, 4'h0, 32'h18, 32'h0, r, e);
      chk("oor_rd_err", {63'd0, e}, 64'd1);
      chk("oor_rd_rdata", {32'd0, r}, 64'd0);
      bus(1'b1, 4'hF, 32'h3FC, 32'h0000_0301, r, e);
      chk("oor_wr_err", {63'd0, e}, 64'd1);
      rd32(32'h10, r); chk("ctrl_unchanged", {32'd0, r}, 64'd0);
      rd32(32'h08, r); chk("cmp_unchanged", {32'd0, r}, 64'hFFFF_CCFF);

      // Reset with a response in flight
      wr32(32'h08, 32'h0);
      wr32(32'h0C, 32'h0);
      wr32(32'h04, 32'h0);
      wr32(32'h00, 32'h55);
      wr32(32'h10, 32'h00FF_FF01);
      rd32(32'h00, r); chk("pre_rst_mtime", {32'd0, r}, 64'h55);
      chk("pre_rst_irq", {63'd0, irq_timer_o}, 64'd1);
      dev_req_i  = 1'b1;
      dev_we_i   = 1'b0;
      dev_addr_i = 32'h00;
      @(posedge clk_i);
      #2;
      chk("inflight_rvalid", {63'd0, dev_rvalid_o}, 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("async_rvalid", {63'd0, dev_rvalid_o}, 64'd0);
      chk("async_rdata", {32'd0, dev_rdata_o}, 64'd0);
      chk("async_irq", {63'd0, irq_timer_o}, 64'd0);
      dev_req_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_rvalid", {63'd0, dev_rvalid_o}, 64'd0);
      rd32(32'h00, r); chk("post_rst_mtime", {32'd0, r}, 64'd0);
      rd32(32'h10, r); chk("post_rst_ctrl", {32'd0, r}, 64'd0);
      rd32(32'h0C, r); chk("post_rst_cmp_hi", {32'd0, r}, 64'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
